// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate formats
// and the ID/EX control bundle.
package rv_pkg;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    pc_src_a;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t CtrlNop = ctrl_t'('0);

    // funct3 -> ALU op; alt is instr[30], which selects SUB only for register-register ops
    function automatic alu_op_e alu_decode(logic [2:0] funct3, logic alt, logic is_reg);
        alu_op_e op;
        case (funct3)
            3'd0:    op = (alt && is_reg) ? AluSub : AluAdd;
            3'd1:    op = AluSll;
            3'd2:    op = AluSlt;
            3'd3:    op = AluSltu;
            3'd4:    op = AluXor;
            3'd5:    op = alt ? AluSra : AluSrl;
            3'd6:    op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate of an instruction word.
module imm_gen
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:7]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    // Select the immediate layout and sign-extend from instr[31]
    always_comb begin
        imm = '0;
        unique case (fmt)
            ImmI:    imm = XLEN'($signed(instr[31:20]));
            ImmS:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            ImmB:    imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            ImmU:    imm = XLEN'($signed({instr[31:12], 12'b0}));
            ImmJ:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21],
                                          1'b0}));
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: register read with WB bypass, control
// decode, immediate build, load-use stall and flush/hold handling.
module id_ex_stage
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_id_valid,
    input  logic [XLEN-1:0] if_id_pc,
    input  logic [31:0]     if_id_instr,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_req,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_op,
    output logic            ex_alu_src,
    output logic            ex_pc_src_a,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    ctrl_t           dec_ctrl;
    ctrl_t           ctrl_q;
    imm_fmt_e        imm_fmt;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            uses_rs1, uses_rs2;
    logic            load_use;

    assign opcode      = if_id_instr[6:0];
    assign rd          = if_id_instr[11:7];
    assign rs1         = if_id_instr[19:15];
    assign rs2         = if_id_instr[24:20];
    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    // Opcode decode into the control bundle, immediate format and source usage
    always_comb begin
        dec_ctrl = CtrlNop;
        imm_fmt  = ImmNone;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        unique case (opcode)
            OpcOp: begin
                dec_ctrl.alu_op    = alu_decode(if_id_instr[14:12], if_id_instr[30], 1'b1);
                dec_ctrl.reg_write = 1'b1;
                uses_rs2           = 1'b1;
            end
            OpcOpImm: begin
                dec_ctrl.alu_op    = alu_decode(if_id_instr[14:12], if_id_instr[30], 1'b0);
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                imm_fmt            = ImmI;
            end
            OpcLoad: begin
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                imm_fmt             = ImmI;
            end
            OpcStore: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                imm_fmt            = ImmS;
                uses_rs2           = 1'b1;
            end
            OpcBranch: begin
                dec_ctrl.alu_op = AluSub;
                dec_ctrl.branch = 1'b1;
                imm_fmt         = ImmB;
                uses_rs2        = 1'b1;
            end
            OpcJal: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.pc_src_a  = 1'b1;
                imm_fmt            = ImmJ;
                uses_rs1           = 1'b0;
            end
            OpcJalr: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                imm_fmt            = ImmI;
            end
            OpcLui: begin
                dec_ctrl.alu_op    = AluPassB;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                imm_fmt            = ImmU;
                uses_rs1           = 1'b0;
            end
            OpcAuipc: begin
                dec_ctrl.pc_src_a  = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                imm_fmt            = ImmU;
                uses_rs1           = 1'b0;
            end
            default: dec_ctrl.illegal = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded; drop them here so EX forwarding ignores them
        if (rd == 5'd0) begin
            dec_ctrl.reg_write = 1'b0;
        end
    end

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (if_id_instr[31:7]),
        .fmt   (imm_fmt),
        .imm   (dec_imm)
    );

    // Operand read: x0 reads as zero, otherwise the same-cycle WB write wins over the RF
    always_comb begin
        rs1_val = rf_rs1_data;
        rs2_val = rf_rs2_data;
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (wb_reg_write && (wb_rd == rs1)) begin
            rs1_val = wb_data;
        end
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (wb_reg_write && (wb_rd == rs2)) begin
            rs2_val = wb_data;
        end
    end

    // Load in EX whose result the IF/ID instruction needs before it is available
    always_comb begin
        load_use = ex_valid && ctrl_q.mem_read && (ex_rd != 5'd0) && if_id_valid &&
                   ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
        stall_req = (load_use || hold) && !flush;
    end

    // ID/EX register: flush > hold > load-use bubble > advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= RESET_PC;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ctrl_q      <= CtrlNop;
        end else if (flush || (!hold && (load_use || !if_id_valid))) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ctrl_q      <= CtrlNop;
        end else if (!hold) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_id_pc;
            ex_imm      <= dec_imm;
            ex_rs1_data <= rs1_val;
            ex_rs2_data <= rs2_val;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ctrl_q      <= dec_ctrl;
        end
    end

    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_pc_src_a   = ctrl_q.pc_src_a;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;
    assign ex_jump       = ctrl_q.jump;
    assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: behavioural reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush, hold;
    logic        stall_req;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic        ex_alu_src, ex_pc_src_a, ex_mem_read, ex_mem_write, ex_reg_write;
    logic        ex_mem_to_reg, ex_branch, ex_jump, ex_illegal;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .rf_rs1_addr   (rf_rs1_addr),
        .rf_rs2_addr   (rf_rs2_addr),
        .rf_rs1_data   (rf_rs1_data),
        .rf_rs2_data   (rf_rs2_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .hold          (hold),
        .stall_req     (stall_req),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_alu_op     (ex_alu_op),
        .ex_alu_src    (ex_alu_src),
        .ex_pc_src_a   (ex_pc_src_a),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_illegal    (ex_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model; x0 deliberately holds garbage to prove the DUT zeroes it
    logic [31:0] rf [32];
    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + i;
            rf[0] <= 32'h0000BAD0;
        end else if (wb_reg_write && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        alu_src, pc_a, mr, mw, rw, m2r, br, j, ill;
    } exp_t;

    exp_t m;

    function automatic logic [31:0] read_reg(logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    // Reference decode from the ISA tables; SUB/SRA sit one code above ADD/SRL
    function automatic exp_t model_decode(logic [31:0] i, logic [31:0] pc);
        exp_t e;
        int   base [8];
        logic [2:0] f3;
        base = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3 = i[14:12];
        e = '0;
        e.valid = 1'b1;
        e.pc = pc;
        e.rd = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.d1 = read_reg(i[19:15]);
        e.d2 = read_reg(i[24:20]);
        case (i[6:0])
            7'h33: begin
                e.alu = 4'(base[f3] + (((f3 == 0 || f3 == 5) && i[30]) ? 1 : 0));
                e.rw = 1'b1;
            end
            7'h13: begin
                e.alu = 4'(base[f3] + ((f3 == 5 && i[30]) ? 1 : 0));
                e.alu_src = 1'b1; e.rw = 1'b1;
                e.imm = 32'($signed(i[31:20]));
            end
            7'h03: begin
                e.alu_src = 1'b1; e.mr = 1'b1; e.rw = 1'b1; e.m2r = 1'b1;
                e.imm = 32'($signed(i[31:20]));
            end
            7'h23: begin
                e.alu_src = 1'b1; e.mw = 1'b1;
                e.imm = 32'($signed({i[31:25], i[11:7]}));
            end
            7'h63: begin
                e.alu = 4'd1; e.br = 1'b1;
                e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            end
            7'h6F: begin
                e.j = 1'b1; e.rw = 1'b1; e.pc_a = 1'b1;
                e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            end
            7'h67: begin
                e.j = 1'b1; e.rw = 1'b1; e.alu_src = 1'b1;
                e.imm = 32'($signed(i[31:20]));
            end
            7'h37: begin
                e.alu = 4'd10; e.alu_src = 1'b1; e.rw = 1'b1;
                e.imm = {i[31:12], 12'h000};
            end
            7'h17: begin
                e.pc_a = 1'b1; e.alu_src = 1'b1; e.rw = 1'b1;
                e.imm = {i[31:12], 12'h000};
            end
            default: e.ill = 1'b1;
        endcase
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic model_load_use();
        logic [6:0] op;
        logic u1, u2;
        op = if_id_instr[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return m.valid && m.mr && m.rd != 5'd0 && if_id_valid &&
               ((u1 && m.rd == if_id_instr[19:15]) || (u2 && m.rd == if_id_instr[24:20]));
    endfunction

    // Model state update at each edge, same priority order as the pipeline contract
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m <= '0;
        end else if (flush) begin
            m <= '0;
        end else if (hold) begin
            m <= m;
        end else if (model_load_use() || !if_id_valid) begin
            m <= '0;
        end else begin
            m <= model_decode(if_id_instr, if_id_pc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare DUT against the model on the falling edge, away from input changes
    always @(negedge clk) begin
        check("stall_req", 32'(stall_req), 32'((model_load_use() || hold) && !flush));
        check("ex_valid", 32'(ex_valid), 32'(m.valid));
        check("ex_pc", ex_pc, m.pc);
        check("ex_imm", ex_imm, m.imm);
        check("ex_rs1_data", ex_rs1_data, m.d1);
        check("ex_rs2_data", ex_rs2_data, m.d2);
        check("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
        check("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
        check("ex_rd", 32'(ex_rd), 32'(m.rd));
        check("ex_alu_op", 32'(ex_alu_op), 32'(m.alu));
        check("ex_alu_src", 32'(ex_alu_src), 32'(m.alu_src));
        check("ex_pc_src_a", 32'(ex_pc_src_a), 32'(m.pc_a));
        check("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        check("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
        check("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        check("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
        check("ex_branch", 32'(ex_branch), 32'(m.br));
        check("ex_jump", 32'(ex_jump), 32'(m.j));
        check("ex_illegal", 32'(ex_illegal), 32'(m.ill));
    end

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd,
                          input logic fl, input logic hd);
        if_id_valid  = v;
        if_id_pc     = pc;
        if_id_instr  = instr;
        wb_reg_write = wbw;
        wb_rd        = wbrd;
        wb_data      = wbd;
        flush        = fl;
        hold         = hd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [3:0]  alu;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h123454B7, 32'h12345000, 4'd10};  // lui  x9,0x12345
        vecs[1] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 4'd0};   // jal  x1,-4
        vecs[2] = '{32'h0020A423, 32'h00000008, 4'd0};   // sw   x2,8(x1)
        vecs[3] = '{32'h4032D293, 32'h00000403, 4'd7};   // srai x5,x5,3
        vecs[4] = '{32'hFE208CE3, 32'hFFFFFFF8, 4'd1};   // beq  x1,x2,-8

        set_in(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset ex_valid", 32'(ex_valid), 32'h0);
        check("reset ex_pc", ex_pc, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // addi x5,x0,7
        set_in(1'b1, 32'h100, 32'h00700293, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        check("addi ex_rd", 32'(ex_rd), 32'd5);
        check("addi ex_imm", ex_imm, 32'd7);
        check("addi ex_alu_op", 32'(ex_alu_op), 32'd0);
        check("addi ex_alu_src", 32'(ex_alu_src), 32'd1);
        check("addi ex_reg_write", 32'(ex_reg_write), 32'd1);

        // Immediate formats and ALU op mapping
        for (int k = 0; k < 5; k++) begin
            set_in(1'b1, 32'h200 + 32'(4 * k), vecs[k].instr, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
            tick();
            check($sformatf("vec%0d ex_imm", k), ex_imm, vecs[k].imm);
            check($sformatf("vec%0d ex_alu_op", k), 32'(ex_alu_op), 32'(vecs[k].alu));
        end

        // lw x6,0(x1) then add x7,x6,x2: one stall cycle and one bubble
        set_in(1'b1, 32'h104, 32'h0000A303, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h108, 32'h002303B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1 check("load-use stall_req", 32'(stall_req), 32'd1);
        tick();
        check("load-use bubble", 32'(ex_valid), 32'd0);
        #1 check("post-bubble stall_req", 32'(stall_req), 32'd0);
        tick();
        check("add issued ex_rd", 32'(ex_rd), 32'd7);
        check("add issued ex_rs1_data", ex_rs1_data, 32'h00001006);

        // add x4,x3,x3 while WB writes x3
        set_in(1'b1, 32'h10C, 32'h00318233, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        check("bypass ex_rs1_data", ex_rs1_data, 32'hDEADBEEF);
        check("bypass ex_rs2_data", ex_rs2_data, 32'hDEADBEEF);

        // Flush overrides a load-use hazard
        set_in(1'b1, 32'h110, 32'h0000A303, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'h114, 32'h002303B3, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        #1 check("flush stall_req", 32'(stall_req), 32'd0);
        tick();
        check("flush bubble", 32'(ex_valid), 32'd0);

        // addi x0,x0,0 with WB writing rd=0: no bypass from x0
        set_in(1'b1, 32'h118, 32'h00000013, 1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0);
        tick();
        check("x0 ex_rs1_data", ex_rs1_data, 32'h0);
        check("x0 ex_reg_write", 32'(ex_reg_write), 32'd0);

        // sub x8,x1,x2 then hold for three cycles
        set_in(1'b1, 32'h11C, 32'h40208433, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 32'h120, 32'h0000057F, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
            #1 check("hold stall_req", 32'(stall_req), 32'd1);
            tick();
            check("hold ex_rd", 32'(ex_rd), 32'd8);
            check("hold ex_alu_op", 32'(ex_alu_op), 32'd1);
            check("hold ex_pc", ex_pc, 32'h11C);
        end

        // Unknown opcode 0x7F with rd=x10
        set_in(1'b1, 32'h120, 32'h0000057F, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        check("illegal ex_illegal", 32'(ex_illegal), 32'd1);
        check("illegal ex_valid", 32'(ex_valid), 32'd1);
        check("illegal ex_reg_write", 32'(ex_reg_write), 32'd0);

        // Asynchronous reset while ex_valid=1
        set_in(1'b1, 32'h124, 32'h00700293, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        check("pre-reset ex_valid", 32'(ex_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("async reset ex_valid", 32'(ex_valid), 32'd0);
        check("async reset ex_pc", ex_pc, 32'h0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
